// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory with a FIFO store buffer in front of it.
//
// Stores are accepted into a small store buffer and drained into the RAM later.
// A drain uses the single RAM port in any cycle that no load needs it, and it is
// forced when the buffer is full. Loads read the RAM with a registered read. The
// youngest buffered store to the same word is forwarded ahead of the RAM data.
// Load results appear one cycle after the RAM read.
//
// Optional feature: define DMEM_MMIO_EN to add a 32-bit MMIO register at byte
// address 0x0000_0100. This adds the MmioData and MmioStrobe outputs. Without
// the macro, address 0x100 is ordinary RAM and aliases word 0x40 mod DEPTH.
//
// Parameters
//   DEPTH      RAM size in 32-bit words (power of two)
//   SB_DEPTH   store-buffer entries (power of two, >= 2)
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   MemWrite    store request
//   MemRead     load request
//   DataAddr    byte address shared by load and store
//   WriteData   store data
//   ReadData    registered load result, held while ReadValid is low
//   ReadValid   one-cycle pulse for a new load result
//   Stall       request not accepted this cycle (store buffer full)
//   SbEmpty     store buffer empty
//   MmioData    MMIO register contents      (DMEM_MMIO_EN only)
//   MmioStrobe  one-cycle pulse on MMIO store (DMEM_MMIO_EN only)
module dmem_responder #(
  parameter int DEPTH    = 64,
  parameter int SB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Stall,
  output logic        SbEmpty
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] MmioData,
  output logic        MmioStrobe
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SBW = $clog2(SB_DEPTH);
  localparam int CW  = SBW + 1;
  localparam logic [CW-1:0] SB_FULL = CW'(SB_DEPTH);

  // Request decode
  logic [AW-1:0] wordIdx;
  logic          accept;
  logic          storeAcc;
  logic          loadAcc;
  logic          mmioHit;
  logic          enq;
  logic          drain;
  logic          sbFull;

  // Store buffer
  logic [AW-1:0]  sbAddr [SB_DEPTH];
  logic [31:0]    sbData [SB_DEPTH];
  logic [SBW-1:0] wrPtrReg;
  logic [SBW-1:0] rdPtrReg;
  logic [CW-1:0]  countReg;
  logic [CW-1:0]  countNext;
  logic [SB_DEPTH-1:0] slotMatch;

  // Forwarding and load pipeline
  logic           fwdHitNext;
  logic [31:0]    fwdDataNext;
  logic [SBW-1:0] slot;
  logic           loadPendReg;
  logic           fwdHitReg;
  logic [31:0]    fwdDataReg;

  // RAM
  logic [31:0] ram [DEPTH];
  logic [31:0] ramQ;

`ifdef DMEM_MMIO_EN
  logic [31:0] mmioDataReg;
  logic        mmioStrobeReg;
  assign mmioHit    = (DataAddr == 32'h0000_0100);
  assign MmioData   = mmioDataReg;
  assign MmioStrobe = mmioStrobeReg;
`else
  // Upper address bits and byte offset are ignored, so addresses alias.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{DataAddr[31:AW+2], DataAddr[1:0]};
  assign mmioHit        = 1'b0;
`endif

  assign wordIdx  = DataAddr[AW+1:2];
  assign sbFull   = (countReg == SB_FULL);
  assign Stall    = sbFull;
  assign SbEmpty  = (countReg == '0);
  assign accept   = !rst && !sbFull;
  assign storeAcc = accept && MemWrite;
  assign loadAcc  = accept && MemRead;
  assign enq      = storeAcc && !mmioHit;
  // A full buffer always drains. Otherwise a load owns the RAM port and the
  // drain waits. A full buffer stalls, so a load is never accepted alongside
  // a forced drain.
  assign drain    = !rst && (sbFull || (!loadAcc && !SbEmpty));

  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : gSlotMatch
      assign slotMatch[gi] = (sbAddr[gi] == wordIdx);
    end
  endgenerate

  // Walk the buffer from oldest to youngest so the last match wins. A store
  // accepted in the same cycle is younger than every buffered entry. Load and
  // store share DataAddr, so that store always matches the load.
  always_comb begin
    fwdHitNext  = 1'b0;
    fwdDataNext = '0;
    slot        = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = rdPtrReg + SBW'(i);
      if ((CW'(i) < countReg) && slotMatch[slot]) begin
        fwdHitNext  = 1'b1;
        fwdDataNext = sbData[slot];
      end
    end
    if (enq) begin
      fwdHitNext  = 1'b1;
      fwdDataNext = WriteData;
    end
`ifdef DMEM_MMIO_EN
    if (mmioHit) begin
      fwdHitNext  = 1'b1;
      fwdDataNext = storeAcc ? WriteData : mmioDataReg;
    end
`endif
  end

  always_comb begin
    countNext = countReg;
    if (enq && !drain) begin
      countNext = countReg + CW'(1);
    end else if (!enq && drain) begin
      countNext = countReg - CW'(1);
    end
  end

  // Store-buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      countReg <= countNext;
      if (enq) begin
        wrPtrReg <= wrPtrReg + SBW'(1);
      end
      if (drain) begin
        rdPtrReg <= rdPtrReg + SBW'(1);
      end
    end
  end

  // Store-buffer payload needs no reset; countReg qualifies every entry.
  always_ff @(posedge clk) begin
    if (enq) begin
      sbAddr[wrPtrReg] <= wordIdx;
      sbData[wrPtrReg] <= WriteData;
    end
  end

  // Single-port RAM with a registered read. Contents survive reset. A drain
  // and a load never share a cycle.
  always_ff @(posedge clk) begin
    if (drain) begin
      ram[sbAddr[rdPtrReg]] <= sbData[rdPtrReg];
    end
    if (loadAcc) begin
      ramQ <= ram[wordIdx];
    end
  end

  // Load return. The forwarding decision is captured in the same cycle as the
  // RAM read. The result is selected one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      loadPendReg <= 1'b0;
      fwdHitReg   <= 1'b0;
      fwdDataReg  <= '0;
      ReadValid   <= 1'b0;
      ReadData    <= '0;
    end else begin
      loadPendReg <= loadAcc;
      fwdHitReg   <= fwdHitNext;
      fwdDataReg  <= fwdDataNext;
      ReadValid   <= loadPendReg;
      if (loadPendReg) begin
        ReadData <= fwdHitReg ? fwdDataReg : ramQ;
      end
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mmioDataReg   <= '0;
      mmioStrobeReg <= 1'b0;
    end else begin
      mmioStrobeReg <= storeAcc && mmioHit;
      if (storeAcc && mmioHit) begin
        mmioDataReg <= WriteData;
      end
    end
  end
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter SB_DEPTH, default 2, store-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port MemWrite  input  1  store request from core.
REQ-006 SHALL have port MemRead  input  1  load request from core.
REQ-007 SHALL have port DataAddr  input  32  byte address of request.
REQ-008 SHALL have port WriteData  input  32  store data.
REQ-009 SHALL have port ReadData  output  32  load result, registered.
REQ-010 SHALL have port ReadValid  output  1  one-cycle pulse marking ReadData as a new load result.
REQ-011 SHALL have port Stall  output  1  request not accepted this cycle; core holds request.
REQ-012 SHALL have port SbEmpty  output  1  store buffer holds no entries.

Function
REQ-013 SHALL form word index from DataAddr[log2(DEPTH)+1:2]; DataAddr[1:0] and upper bits ignored (aliasing by design).
REQ-014 SHALL accept a request at a rising edge only when Stall=0; with Stall=1 MemWrite/MemRead SHALL have no effect.
REQ-015 SHALL assert Stall combinationally when store-buffer count equals SB_DEPTH, and only then.
REQ-016 SHALL enqueue an accepted store {word index, WriteData} into a FIFO store buffer; pointers wrap modulo SB_DEPTH.
REQ-017 SHALL serve the single RAM port each cycle with: drain of oldest entry when buffer full; else an accepted load; else drain of oldest entry if non-empty; else idle.
REQ-018 SHALL return an accepted load at edge N as ReadData with ReadValid=1 after edge N+1 (latency 1), ReadValid low otherwise.
REQ-019 SHALL forward to a load the data of the youngest buffered store with matching word index, overriding RAM content.
REQ-020 SHALL, when MemWrite and MemRead are accepted in the same cycle, treat the store as older; the load returns WriteData if indices match.
REQ-021 SHALL permit enqueue and drain in the same cycle; count unchanged, Stall unchanged.
REQ-022 SHALL hold ReadData at its last value while ReadValid=0.
REQ-023 SHALL drive SbEmpty=1 exactly when count=0.

Reset
REQ-024 SHALL on rst: count=0, pointers=0, ReadData=0, ReadValid=0, Stall=0, SbEmpty=1.
REQ-025 SHALL discard buffered, undrained stores on rst asserted mid-operation; RAM contents SHALL NOT be reset.
REQ-026 SHALL ignore MemWrite/MemRead in any cycle with rst=1.

Configuration
REQ-027 SHALL compile in, under macro DMEM_MMIO_EN, a 32-bit MMIO register at byte address 0x0000_0100 (full 32-bit compare) with extra outputs MmioData (32) and MmioStrobe (1).
REQ-028 SHALL, with DMEM_MMIO_EN defined, capture an accepted store to 0x100 into MmioData at that edge, pulse MmioStrobe one cycle, bypass the store buffer, and return MmioData for loads from 0x100 at latency 1; MmioData resets to 0.
REQ-029 SHALL, without DMEM_MMIO_EN, omit MmioData/MmioStrobe and treat 0x100 as ordinary RAM (word index 0x40 mod DEPTH).

Verification
REQ-030 SHALL cover: store 0xDEADBEEF to 0x10, idle 3 cycles, load 0x10 -> ReadData=0xDEADBEEF, ReadValid 1 cycle after acceptance, SbEmpty=1 before load.
REQ-031 SHALL cover: store 0x11111111 @0x20 then immediately load 0x20 -> forwarded 0x11111111 while SbEmpty=0.
REQ-032 SHALL cover: stores 0xA,0xB @0x4 back-to-back then load 0x4 -> 0xB (youngest match).
REQ-033 SHALL cover: continuous stores with continuous loads -> Stall=1 when count=2, drain occurs, no store lost; final reads match all written values.
REQ-034 SHALL cover: 2 stores buffered, rst for 1 cycle, then load those addresses -> prior RAM contents, ReadValid=0 and SbEmpty=1 during reset.
REQ-035 SHALL cover (DMEM_MMIO_EN): store 0x0000_0041 to 0x100 -> MmioData=0x41, MmioStrobe 1 cycle, RAM word 0x40 unchanged.
